// File: rtl/keypad_entry_display.sv
// Keypad entry buffer with debounce and a multiplexed seven-segment driver; LEADING_ZERO_BLANK_EN blanks unentered digits.
// Latency: key_pulse STABLE_CYCLES after the first sampled press; buffer +1 cycle; seg/dig_sel registered together.
// Backpressure: none; lock mode drops keys when full, and clr beats a coincident key.
module keypad_entry_display #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 50_000,
    parameter int REFRESH_DIV   = 50_000,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    mode,
    input  logic                    clr,
    output logic [6:0]              seg,
    output logic [DW-1:0]           dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    key_pulse,
    output logic [CW-1:0]           entry_cnt,
    output logic                    full
);
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] C_FULL = CW'(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    state_t        state;
    logic [SW-1:0] stab_cnt;
    logic [3:0]    code_lat;
    logic [RW-1:0] pre_cnt;
    logic [DW-1:0] sel_next;
    logic [3:0]    nib;
    logic [6:0]    glyph;

    assign full = (entry_cnt == C_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stab_cnt  <= '0;
            code_lat  <= '0;
            key_pulse <= 1'b0;
        end else begin
            key_pulse <= 1'b0;
            case (state)
                IDLE: if (key_valid) begin
                    state    <= PRESS_WAIT;
                    code_lat <= key_code;
                    stab_cnt <= '0;
                end
                PRESS_WAIT: begin
                    if (!key_valid) begin
                        state <= IDLE;
                    end else if (key_code != code_lat) begin
                        code_lat <= key_code;
                        stab_cnt <= '0;
                    end else if (stab_cnt == S_LAST) begin
                        state     <= HELD;
                        key_pulse <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + SW'(1);
                    end
                end
                HELD: if (!key_valid) begin
                    state    <= REL_WAIT;
                    stab_cnt <= '0;
                end
                REL_WAIT: begin
                    if (key_valid) begin
                        state <= HELD;
                    end else if (stab_cnt == S_LAST) begin
                        state <= IDLE;
                    end else begin
                        stab_cnt <= stab_cnt + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // code_lat still holds the accepted key while key_pulse is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits    <= '0;
            entry_cnt <= '0;
        end else if (clr) begin
            digits    <= '0;
            entry_cnt <= '0;
        end else if (key_pulse && (!mode || !full)) begin
            digits <= {digits[4*NUM_DIGITS-5:0], code_lat};
            if (!full)
                entry_cnt <= entry_cnt + CW'(1);
        end
    end

    always_comb begin
        sel_next = dig_sel;
        if (pre_cnt == R_LAST)
            sel_next = (dig_sel == D_LAST) ? '0 : dig_sel + DW'(1);
        nib = digits[{sel_next, 2'b00} +: 4];
        case (nib)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // digit 0 stays visible even with nothing entered
        if (CW'(sel_next) >= ((entry_cnt == '0) ? CW'(1) : entry_cnt))
            glyph = 7'b0000000;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            dig_sel <= '0;
            seg     <= 7'b1111110;
        end else begin
            pre_cnt <= (pre_cnt == R_LAST) ? '0 : pre_cnt + RW'(1);
            dig_sel <= sel_next;
            seg     <= glyph;
        end
    end
endmodule

// File: tb/tb_keypad_entry_display.sv
// Bench for keypad_entry_display (N=4, STABLE=4, DIV=3): run-length model checked every cycle plus directed literals.
module tb_keypad_entry_display;
    localparam int N = 4;
    localparam int S = 4;
    localparam int R = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        mode = 1'b0;
    logic        clr = 1'b0;
    logic [6:0]  seg;
    logic [1:0]  dig_sel;
    logic [15:0] digits;
    logic        key_pulse;
    logic [2:0]  entry_cnt;
    logic        full;

    keypad_entry_display #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .mode(mode),
        .clr(clr), .seg(seg), .dig_sel(dig_sel), .digits(digits), .key_pulse(key_pulse),
        .entry_cnt(entry_cnt), .full(full));

    always #5 clk = ~clk;

    int vectors = 0;
    int fails = 0;
    int pulse_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] glyph_tab [16];
    initial glyph_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model: a press counts after S+1 consecutive same-code samples, a release after S+1 idle samples.
    int          m_edges, run_len, low_len, m_cnt, m_sel;
    logic [3:0]  run_code, m_pcode;
    logic        m_held, m_pulse;
    logic [15:0] m_digits;
    logic [6:0]  m_seg;

    function automatic logic [6:0] shown(input logic [15:0] d, input int cnt, input int sel);
        logic [3:0] n;
        n = d[sel*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (sel >= ((cnt == 0) ? 1 : cnt)) return 7'h00;
`endif
        return glyph_tab[n];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edges = 0; run_len = 0; low_len = 0; m_held = 1'b0; m_pulse = 1'b0;
            run_code = 4'h0; m_pcode = 4'h0; m_digits = 16'h0; m_cnt = 0; m_sel = 0;
            m_seg = 7'h7E;
        end else begin
            m_edges++;
            m_sel = (m_edges / R) % N;
            m_seg = shown(m_digits, m_cnt, m_sel);
            if (clr) begin
                m_digits = 16'h0;
                m_cnt = 0;
            end else if (m_pulse && (!mode || m_cnt < N)) begin
                m_digits = {m_digits[11:0], m_pcode};
                if (m_cnt < N) m_cnt++;
            end
            if (key_valid) begin
                low_len = 0;
                if (run_len > 0 && key_code == run_code) run_len++;
                else begin run_len = 1; run_code = key_code; end
            end else begin
                run_len = 0;
                low_len++;
            end
            m_pulse = 1'b0;
            if (!m_held && run_len >= S + 1) begin
                m_pulse = 1'b1; m_held = 1'b1; m_pcode = run_code;
            end
            if (low_len >= S + 1) m_held = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dig_sel", 32'(dig_sel), 32'(m_sel));
        chk("digits", 32'(digits), 32'(m_digits));
        chk("key_pulse", 32'(key_pulse), 32'(m_pulse));
        chk("entry_cnt", 32'(entry_cnt), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == N));
        if (key_pulse) pulse_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c, input int hold);
        key_valid = 1'b1; key_code = c;
        step(hold);
        key_valid = 1'b0;
        step(7);
    endtask

    int p0, waited;
    logic [6:0] exp_hi;

    initial begin
        step(2);
        chk("rst_seg", 32'(seg), 32'h7E);
        chk("rst_dig_sel", 32'(dig_sel), 32'h0);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_entry_cnt", 32'(entry_cnt), 32'h0);
        rst = 1'b1;
        step(2);

        // glitchy press must not count
        p0 = pulse_cnt;
        key_valid = 1'b1; key_code = 4'h5; step(2);
        key_valid = 1'b0; step(1);
        key_valid = 1'b1; step(2);
        key_valid = 1'b0; step(7);
        chk("glitch_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        press(4'h5, 8);
        chk("stable_one_pulse", 32'(pulse_cnt - p0), 32'd1);
        chk("digits_after_5", 32'(digits), 32'h0005);

        // shift mode overflow, then lock mode when full
        clr = 1'b1; step(1); clr = 1'b0;
        mode = 1'b0;
        for (int i = 1; i <= 5; i++) press(4'(i), 8);
        chk("shift_digits", 32'(digits), 32'h2345);
        chk("shift_entry_cnt", 32'(entry_cnt), 32'd4);
        chk("shift_full", 32'(full), 32'd1);
        mode = 1'b1;
        p0 = pulse_cnt;
        press(4'h6, 8);
        chk("lock_pulse", 32'(pulse_cnt - p0), 32'd1);
        chk("lock_digits", 32'(digits), 32'h2345);

        // long hold gives a single pulse
        p0 = pulse_cnt;
        press(4'hA, 100);
        chk("hold_one_pulse", 32'(pulse_cnt - p0), 32'd1);

        // clr coincident with the pulse drops the key
        mode = 1'b0;
        key_valid = 1'b1; key_code = 4'hC;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            step(1); waited++;
            if (key_pulse) break;
        end
        chk("press_latency", 32'(waited), 32'd5);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("clr_digits", 32'(digits), 32'h0);
        chk("clr_entry_cnt", 32'(entry_cnt), 32'd0);
        key_valid = 1'b0; step(7);

        // display scan of 00A7 with two entries
        press(4'hA, 8);
        press(4'h7, 8);
        chk("scan_digits", 32'(digits), 32'h00A7);
`ifdef LEADING_ZERO_BLANK_EN
        exp_hi = 7'h00;
`else
        exp_hi = 7'h7E;
`endif
        for (int i = 0; i < 12; i++) begin
            step(1);
            case (dig_sel)
                2'd0: chk("scan_seg0", 32'(seg), 32'h70);
                2'd1: chk("scan_seg1", 32'(seg), 32'h77);
                default: chk("scan_seg_hi", 32'(seg), 32'(exp_hi));
            endcase
        end

        // reset in the middle of a press
        key_valid = 1'b1; key_code = 4'h9; step(2);
        rst = 1'b0; step(1);
        key_valid = 1'b0; step(1);
        chk("midrst_digits", 32'(digits), 32'h0);
        rst = 1'b1;
        p0 = pulse_cnt;
        step(8);
        chk("midrst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        press(4'h9, 8);
        chk("midrst_fresh_pulse", 32'(pulse_cnt - p0), 32'd1);
        chk("midrst_fresh_digits", 32'(digits), 32'h0009);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
